// File: rtl/ca_prng.sv
// ca_prng: circular one-dimensional cellular-automaton PRNG feeding a serial output shift register.
// Optional feature macro: CA_PRNG_RULE_WR_EN (rule register writable at addr 1; otherwise the rule is RULE_INIT).
module ca_prng #(
   parameter int unsigned      WIDTH     = 15,
   parameter int unsigned      OUT_W     = 8,
   parameter int unsigned      TAP       = 7,
   parameter logic [7:0]       RULE_INIT = 8'd30,
   parameter logic [WIDTH-1:0] SEED      = WIDTH'({7'h01, 8'h77}),
   parameter logic [OUT_W-1:0] Z_INIT    = OUT_W'(8'h77)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       addr,
   input  logic             write_en,
   input  logic [7:0]       din,
   input  logic             rd_en,
   output logic [OUT_W-1:0] dout,
   output logic             dout_valid
);

   localparam int unsigned      CNT_W   = $clog2(OUT_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   // Applies the Wolfram rule to every cell; neighbours wrap around the ring.
   function automatic logic [WIDTH-1:0] ca_step(input logic [WIDTH-1:0] cells,
                                                input logic [7:0]       rule);
      logic [WIDTH-1:0] left_v;
      logic [WIDTH-1:0] right_v;
      logic [WIDTH-1:0] result;
      left_v  = {cells[WIDTH-2:0], cells[WIDTH-1]};
      right_v = {cells[0], cells[WIDTH-1:1]};
      result  = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         result[i] = rule[{left_v[i], cells[i], right_v[i]}];
      end
      return result;
   endfunction

   logic [WIDTH-1:0] q_r;
   logic [OUT_W-1:0] z_r;
   logic             run_r;
   logic             step_r;
   logic [CNT_W-1:0] cnt_r;
   logic             valid_r;
   logic [7:0]       rule_s;

   logic             seed_wr_s;
   logic             ctrl_wr_s;
   logic             adv_s;
   logic             lock_s;
   logic [WIDTH-1:0] nxt_s;
   logic [OUT_W:0]   zcat_s;
   logic [WIDTH-1:0] q_nxt_s;
   logic [OUT_W-1:0] z_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             run_nxt_s;
   logic             step_nxt_s;
   logic             valid_nxt_s;

`ifdef CA_PRNG_RULE_WR_EN
   logic       rule_wr_s;
   logic [7:0] rule_r;

   // Rule register; a new rule is used from the next advance onward.
   always_ff @(posedge clk) begin
      if (rst) begin
         rule_r <= RULE_INIT;
      end else if (rule_wr_s) begin
         rule_r <= din;
      end else begin
         rule_r <= rule_r;
      end
   end

   assign rule_s = rule_r;
`else
   assign rule_s = RULE_INIT;
`endif

   // Register-select decode of the write strobe.
   always_comb begin
      seed_wr_s = 1'b0;
      ctrl_wr_s = 1'b0;
`ifdef CA_PRNG_RULE_WR_EN
      rule_wr_s = 1'b0;
`endif
      case (addr)
         8'd0:    seed_wr_s = write_en;
`ifdef CA_PRNG_RULE_WR_EN
         8'd1:    rule_wr_s = write_en;
`endif
         8'd2:    ctrl_wr_s = write_en;
         default: seed_wr_s = 1'b0;
      endcase
   end

   assign adv_s  = run_r | step_r;
   assign lock_s = (q_r == {WIDTH{1'b0}});
   assign nxt_s  = ca_step(q_r, rule_s);
   assign zcat_s = {z_r, nxt_s[TAP]};

   // Next-state for automaton, shift register and fresh counter.
   // Seed write outranks lock-up reload, which outranks a normal advance.
   always_comb begin
      q_nxt_s   = q_r;
      z_nxt_s   = z_r;
      cnt_nxt_s = cnt_r;
      if (seed_wr_s) begin
         q_nxt_s   = {SEED[WIDTH-1:8], din};
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (adv_s) begin
         z_nxt_s = zcat_s[OUT_W-1:0];
         if (lock_s) begin
            q_nxt_s = SEED;
         end else begin
            q_nxt_s = nxt_s;
         end
         if (rd_en) begin
            cnt_nxt_s = CNT_ONE;
         end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = cnt_r;
         end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
         end
      end else if (rd_en) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Control register: run persists, step is a one-cycle pulse.
   always_comb begin
      run_nxt_s  = run_r;
      step_nxt_s = 1'b0;
      if (ctrl_wr_s) begin
         run_nxt_s  = din[0];
         step_nxt_s = din[1];
      end else begin
         run_nxt_s  = run_r;
         step_nxt_s = 1'b0;
      end
   end

   assign valid_nxt_s = (cnt_nxt_s == CNT_MAX);

   // State registers; dout_valid is registered alongside the counter it mirrors.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r     <= SEED;
         z_r     <= Z_INIT;
         run_r   <= 1'b1;
         step_r  <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         valid_r <= 1'b0;
      end else begin
         q_r     <= q_nxt_s;
         z_r     <= z_nxt_s;
         run_r   <= run_nxt_s;
         step_r  <= step_nxt_s;
         cnt_r   <= cnt_nxt_s;
         valid_r <= valid_nxt_s;
      end
   end

   assign dout       = z_r;
   assign dout_valid = valid_r;

endmodule

// File: doc/ca_prng.md
CA_PRNG -- requirements
Module: ca_prng

Interface
REQ-001 Parameter WIDTH, default 15, number of cells in the circular automaton (range 9..64).
REQ-002 Parameter OUT_W, default 8, width of the output shift register and dout (range 1..WIDTH).
REQ-003 Parameter TAP, default 7, index of the cell sampled into the output shift register (range 0..WIDTH-1).
REQ-004 Parameter RULE_INIT, default 8'd30, Wolfram rule applied after reset.
REQ-005 Parameter SEED, default {7'h01, 8'h77} zero-extended to WIDTH, automaton state after reset.
REQ-006 Parameter Z_INIT, default 8'h77 truncated or zero-extended to OUT_W, shift-register value after reset.
REQ-007 Timing: one clock; reset is synchronous and active-high.
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 addr  input  8  register select for writes: 0 = seed, 1 = rule, 2 = control.
REQ-011 write_en  input  1  write strobe, sampled on the rising edge of clk.
REQ-012 din  input  8  write data.
REQ-013 rd_en  input  1  consumer acknowledge that dout has been taken.
REQ-014 dout  output  OUT_W  output shift register contents.
REQ-015 dout_valid  output  1  high when OUT_W fresh bits have been shifted in since the last rd_en or reset.

Function
REQ-016 Next state of cell i SHALL be rule[{q[i-1], q[i], q[i+1]}], with the indices wrapping modulo WIDTH (cell 0's left neighbour is WIDTH-1; cell WIDTH-1's right neighbour is 0).
REQ-017 Advance condition: an advance occurs on a cycle when run=1 or step=1, and no state write takes priority that cycle.
REQ-018 On an advance, q SHALL take the next state and z SHALL take {z[OUT_W-2:0], next[TAP]}, with a latency of one clock.
REQ-019 When no advance occurs, q and z SHALL hold their values.
REQ-020 A write to addr 0 SHALL load q with SEED[WIDTH-1:8] concatenated with din, SHALL leave z unchanged, SHALL clear the fresh counter and SHALL suppress the advance in that cycle.
REQ-021 A write to addr 1 SHALL load the rule register with din, taking effect on the next advance.
REQ-022 A write to addr 2 SHALL set run to din[0]; din[1]=1 SHALL set step for exactly one cycle (self-clearing).
REQ-023 Writes to addresses 3..255 SHALL be ignored.
REQ-024 Lock-up recovery: if q is all zeros and an advance is due, q SHALL reload SEED instead of advancing; z SHALL still shift in next[TAP].
REQ-025 Fresh counter: 0..OUT_W, increments on each advance and saturates at OUT_W; dout_valid is (counter == OUT_W).
REQ-026 rd_en SHALL clear the fresh counter to 0; if rd_en coincides with an advance, the counter becomes 1.
REQ-027 rd_en while dout_valid=0 SHALL clear the counter with no other effect.
REQ-028 Priority, highest first: rst, then seed write, then lock-up reload, then advance.

Reset
REQ-029 On rst=1 at a rising edge: q=SEED, z=Z_INIT, rule=RULE_INIT, run=1, step=0, counter=0, dout_valid=0.
REQ-030 A reset asserted mid-operation SHALL override any simultaneous write, advance or rd_en.

Configuration
REQ-031 Macro CA_PRNG_RULE_WR_EN: when defined, the rule register is writable at addr 1 per REQ-021.
REQ-032 When CA_PRNG_RULE_WR_EN is undefined, the rule is the constant RULE_INIT, writes to addr 1 are ignored, and no rule flops are synthesised.

Verification
REQ-033 Default parameters; release rst; first edge with run=1 -> dout=8'hEE, counter=1, dout_valid=0.
REQ-034 Run 8 advances after reset -> dout_valid=1 on the 8th; further advances keep it at 1; rd_en pulse -> dout_valid=0 and counter=1 on the same edge as an advance.
REQ-035 Write addr 2 din=8'h00, then addr 2 din=8'h02 -> q and z freeze, then advance exactly once, then freeze again.
REQ-036 Write addr 0 din=8'hA5 while running -> q=15'h01A5 on the next edge, z unchanged, counter=0.
REQ-037 With CA_PRNG_RULE_WR_EN defined, write rule 8'h00 -> q=0 after one advance; the next advance reloads q=SEED; q then alternates between 0 and SEED.
REQ-038 rst asserted in the same cycle as write_en to addr 0 and rd_en -> all state equals the REQ-029 values.
